// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 text refresh engine.
// The optional clear-before-refresh feature is selected by LCD_REFRESH_CLEAR_EN.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_FETCH,
    ST_CAPTURE,
    ST_CHAR,
    ST_EN_HI,
    ST_WAIT
  } state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_LINE0 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'hC0;

  // Wide enough for the 1.64 ms clear wait at 50 MHz.
  localparam int WAIT_CNT_W = 17;

  function automatic logic [7:0] char_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Down-counter timing the enable-high and post-write wait phases.
// Loading N-1 on entry makes the phase last N cycles; expire is high while the count is zero.
module lcd_strobe_timer
  import lcd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  output logic                  expire
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/lcd_text_refresh.sv
// Copies an 8-word (32-character) text buffer from on-chip memory to a 2x16 HD44780 LCD.
// Define LCD_REFRESH_CLEAR_EN to send a display-clear command before each refresh.
module lcd_text_refresh
  import lcd_pkg::*;
#(
  parameter logic [10:0] BASE_ADDR      = 11'd0,
  parameter int          EN_PULSE_CYC   = 12,
  parameter int          CHAR_WAIT_CYC  = 2500,
  parameter int          CLEAR_WAIT_CYC = 82000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [10:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_clken,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en
);

`ifdef LCD_REFRESH_CLEAR_EN
  localparam logic CLEAR_EN = 1'b1;
`else
  localparam logic CLEAR_EN = 1'b0;
`endif

  localparam logic [WAIT_CNT_W-1:0] EN_LOAD    = WAIT_CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [WAIT_CNT_W-1:0] CHAR_LOAD  = WAIT_CNT_W'(CHAR_WAIT_CYC - 1);
  localparam logic [WAIT_CNT_W-1:0] CLEAR_LOAD = WAIT_CNT_W'(CLEAR_WAIT_CYC - 1);

  state_e      state_q, state_d;
  logic        line_q, line_d;
  logic [2:0]  word_q, word_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] char_q, char_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic        clr_q, clr_d;

  logic                  tmr_load;
  logic [WAIT_CNT_W-1:0] tmr_val;
  logic                  tmr_expire;

  lcd_strobe_timer u_timer (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    word_d   = word_q;
    byte_d   = byte_q;
    char_d   = char_q;
    data_d   = data_q;
    rs_d     = rs_q;
    clr_d    = clr_q;
    tmr_load = 1'b0;
    tmr_val  = EN_LOAD;
    done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          line_d  = 1'b0;
          word_d  = 3'd0;
          byte_d  = 2'd0;
          clr_d   = CLEAR_EN;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        rs_d     = 1'b0;
        data_d   = clr_q ? LCD_CMD_CLEAR : (line_q ? LCD_CMD_LINE1 : LCD_CMD_LINE0);
        tmr_load = 1'b1;
        state_d  = ST_EN_HI;
      end
      ST_FETCH: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        char_d  = mem_readdata;
        state_d = ST_CHAR;
      end
      ST_CHAR: begin
        rs_d     = 1'b1;
        data_d   = char_byte(char_q, byte_q);
        tmr_load = 1'b1;
        state_d  = ST_EN_HI;
      end
      ST_EN_HI: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = clr_q ? CLEAR_LOAD : CHAR_LOAD;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmr_expire) begin
          // rs still holds the type of the write that just finished.
          if (!rs_q) begin
            if (clr_q) begin
              clr_d   = 1'b0;
              state_d = ST_CMD;
            end else begin
              state_d = ST_FETCH;
            end
          end else if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            state_d = ST_CHAR;
          end else if (word_q == 3'd3) begin
            line_d  = 1'b1;
            word_d  = 3'd4;
            byte_d  = 2'd0;
            state_d = ST_CMD;
          end else if (word_q == 3'd7) begin
            done    = 1'b1;
            line_d  = 1'b0;
            word_d  = 3'd0;
            byte_d  = 2'd0;
            state_d = ST_IDLE;
          end else begin
            word_d  = word_q + 3'd1;
            byte_d  = 2'd0;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registering the strobe delays its rise one cycle behind the data/rs update.
  always_comb begin
    en_d = (state_q == ST_EN_HI);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      line_q  <= 1'b0;
      word_q  <= 3'd0;
      byte_q  <= 2'd0;
      char_q  <= 32'd0;
      data_q  <= 8'd0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      char_q  <= char_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign mem_address    = BASE_ADDR + {8'd0, word_q};
  assign mem_chipselect = (state_q == ST_FETCH);
  assign mem_clken      = (state_q == ST_FETCH);
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign lcd_data       = data_q;
  assign lcd_rs         = rs_q;
  assign lcd_rw         = 1'b0;
  assign lcd_en         = en_q;

endmodule
